// File: rtl/stream_arbiter_rr_pkg.sv
// stream_arbiter_rr_pkg: shared width helpers for the stream arbiter slice
package stream_arbiter_rr_pkg;
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_arbiter_rr_if.sv
// stream_arbiter_rr_if: N-to-1 stream bundle between requesters, arbiter and sink
interface stream_arbiter_rr_if import stream_arbiter_rr_pkg::*; #(
  parameter int N_INP = 4,
  parameter int DATA_WIDTH = 32
) ();
  localparam int IDX_WIDTH = idx_width(N_INP);
  logic [N_INP*DATA_WIDTH-1:0] inp_data_i;
  logic [N_INP-1:0] inp_valid_i;
  logic [N_INP-1:0] inp_ready_o;
  logic [DATA_WIDTH-1:0] oup_data_o;
  logic [IDX_WIDTH-1:0] oup_idx_o;
  logic oup_valid_o;
  logic oup_ready_i;
  modport slave (
    input inp_data_i, inp_valid_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
  );
  modport master (
    output inp_data_i, inp_valid_i, oup_ready_i,
    input inp_ready_o, oup_data_o, oup_idx_o, oup_valid_o
  );
endinterface

// File: rtl/stream_arbiter_rr_find_first.sv
// stream_arbiter_rr_find_first: cyclic first-set-bit search starting at a pointer
module stream_arbiter_rr_find_first #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic found
);
  int p;
  // scan from farthest to nearest so the nearest set bit is the last one written
  always_comb begin
    idx = '0;
    found = 1'b0;
    p = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(start) + k) % N;
      if (req[p]) begin
        idx = W'(p);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/stream_arbiter_rr.sv
// stream_arbiter_rr: round-robin N-to-1 stream merger with optional stall lock-in
module stream_arbiter_rr import stream_arbiter_rr_pkg::*; #(
  parameter int N_INP = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_IN = 1
) (
  input logic clk_i,
  input logic rst_ni,
  stream_arbiter_rr_if.slave bus
);
  localparam int IDX_WIDTH = idx_width(N_INP);
  logic [IDX_WIDTH-1:0] rr_ptr_q, lock_idx_q, ff_idx, g;
  logic lock_q, found, hs;
  stream_arbiter_rr_find_first #(.N(N_INP), .W(IDX_WIDTH)) u_ff (
    .req(bus.inp_valid_i),
    .start(rr_ptr_q),
    .idx(ff_idx),
    .found(found)
  );
  // grant selection, output mux and one-hot ready decode
  always_comb begin
    g = lock_q ? lock_idx_q : found ? ff_idx : '0;
    bus.oup_idx_o = g;
    bus.oup_data_o = bus.inp_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    bus.oup_valid_o = bus.inp_valid_i[g];
    hs = bus.oup_valid_o && bus.oup_ready_i;
    bus.inp_ready_o = hs ? N_INP'(1) << g : '0;
  end
  // advance pointer past a completed beat; freeze a stalled grant when locking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (g == IDX_WIDTH'(N_INP - 1)) ? '0 : g + 1'b1;
      lock_q <= 1'b0;
    end else if (LOCK_IN != 0 && bus.oup_valid_o) begin
      lock_q <= 1'b1;
      lock_idx_q <= g;
    end else begin
      lock_q <= 1'b0;
    end
  end
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(bus.inp_ready_o));
  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (LOCK_IN != 0 && bus.oup_valid_o && !bus.oup_ready_i) |=> $stable(bus.oup_data_o));
  a_ptr_range: assert property (@(posedge clk_i) disable iff (!rst_ni) int'(rr_ptr_q) < N_INP);
  a_lock_valid: assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q |-> bus.inp_valid_i[lock_idx_q]);
endmodule
